// File: rtl/chdr_16s_to_8s_if.sv
// CHDR AXI-stream beat: 64-bit data line with last/valid/ready framing.
interface chdr_16s_to_8s_if;
    logic [63:0] tdata;
    logic        tlast;
    logic        tvalid;
    logic        tready;

    modport master (output tdata, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/chdr_16s_to_8s.sv
// Narrows CHDR sc16 payload to sc8, packing two input lines per output line,
// rewriting the header length and optionally replacing the destination SID.
module chdr_16s_to_8s #(
    parameter logic [7:0] BASE  = 8'd0,
    parameter bit         ROUND = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    chdr_16s_to_8s_if.slave          i,
    chdr_16s_to_8s_if.master         o,
    input  logic                     set_stb,
    input  logic [7:0]               set_addr,
    input  logic [31:0]              set_data,
    output logic [31:0]              debug
);

    typedef enum logic [1:0] {
        StHeader = 2'd0,
        StTime   = 2'd1,
        StFirst  = 2'd2,
        StSecond = 2'd3
    } state_e;

    state_e      state_q, state_d, cur_state;
    logic [31:0] hold_q, hold_d;
    logic [16:0] sid_q;

    logic [15:0] hdr_len, in_bytes, out_size;
    logic [31:0] line_bytes;
    logic        set_sid;
    logic [15:0] new_dst;
    logic        unused_set_data;

    assign set_sid         = sid_q[16];
    assign new_dst         = sid_q[15:0];
    assign unused_set_data = ^set_data[31:17];
    assign debug           = {30'd0, state_q};

    function automatic logic [7:0] to_byte(input logic [15:0] c);
        logic [7:0] sum;
        sum = c[15:8] + {7'd0, c[7]};
        if (!ROUND) begin
            return c[15:8];
        end
        // Only positive values can wrap into 0x80; negatives wrap toward zero.
        if (!c[15] && sum == 8'h80) begin
            return 8'h7f;
        end
        return sum;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StHeader;
            hold_q  <= 32'd0;
            sid_q   <= 17'd0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            if (set_stb && set_addr == BASE) begin
                sid_q <= set_data[16:0];
            end
        end
    end

    always_comb begin
        // Present header-state behaviour while in reset so handshakes stay sane.
        cur_state  = rst ? StHeader : state_q;
        hdr_len    = i.tdata[61] ? 16'd16 : 16'd8;
        in_bytes   = i.tdata[47:32] - hdr_len;
        out_size   = hdr_len + (in_bytes >> 1);
        line_bytes = {to_byte(i.tdata[63:48]), to_byte(i.tdata[47:32]),
                      to_byte(i.tdata[31:16]), to_byte(i.tdata[15:0])};

        state_d  = state_q;
        hold_d   = hold_q;
        o.tdata  = i.tdata;
        o.tlast  = i.tlast;
        o.tvalid = i.tvalid;
        i.tready = o.tready;

        unique case (cur_state)
            StHeader: begin
                o.tdata = {i.tdata[63:48], out_size,
                           set_sid ? {i.tdata[15:0], new_dst} : i.tdata[31:0]};
                if (i.tvalid && o.tready) begin
                    if (i.tlast) begin
                        state_d = StHeader;
                    end else if (i.tdata[61]) begin
                        state_d = StTime;
                    end else begin
                        state_d = StFirst;
                    end
                end
            end
            StTime: begin
                if (i.tvalid && o.tready) begin
                    state_d = i.tlast ? StHeader : StFirst;
                end
            end
            StFirst: begin
                if (!i.tlast) begin
                    i.tready = 1'b1;
                    o.tvalid = 1'b0;
                    if (i.tvalid) begin
                        hold_d  = line_bytes;
                        state_d = StSecond;
                    end
                end else begin
                    o.tdata = {line_bytes, 32'd0};
                    o.tlast = 1'b1;
                    if (i.tvalid && o.tready) begin
                        state_d = StHeader;
                    end
                end
            end
            StSecond: begin
                o.tdata = {hold_q, line_bytes};
                if (i.tvalid && o.tready) begin
                    state_d = i.tlast ? StHeader : StFirst;
                end
            end
            default: state_d = StHeader;
        endcase
    end

endmodule

// File: tb/tb_chdr_16s_to_8s.sv
// Directed bench: truncating and rounding instances run in lockstep on the same stream.
module tb_chdr_16s_to_8s;

    logic        clk = 1'b0;
    logic        rst;
    logic        set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic [31:0] debug, debug_r;
    int          total  = 0;
    int          passed = 0;

    chdr_16s_to_8s_if in_if ();
    chdr_16s_to_8s_if out_if ();
    chdr_16s_to_8s_if rin_if ();
    chdr_16s_to_8s_if rout_if ();

    assign rin_if.tdata   = in_if.tdata;
    assign rin_if.tlast   = in_if.tlast;
    assign rin_if.tvalid  = in_if.tvalid;
    assign rout_if.tready = out_if.tready;

    always #5 clk = ~clk;

    chdr_16s_to_8s #(.BASE(8'd0), .ROUND(1'b0)) dut (
        .clk      (clk),
        .rst      (rst),
        .i        (in_if),
        .o        (out_if),
        .set_stb  (set_stb),
        .set_addr (set_addr),
        .set_data (set_data),
        .debug    (debug)
    );

    chdr_16s_to_8s #(.BASE(8'd0), .ROUND(1'b1)) dut_r (
        .clk      (clk),
        .rst      (rst),
        .i        (rin_if),
        .o        (rout_if),
        .set_stb  (set_stb),
        .set_addr (set_addr),
        .set_data (set_data),
        .debug    (debug_r)
    );

    task automatic drive(input logic [63:0] d, input logic l);
        @(negedge clk);
        in_if.tdata  = d;
        in_if.tlast  = l;
        in_if.tvalid = 1'b1;
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        in_if.tvalid = 1'b0;
        in_if.tlast  = 1'b0;
        #1;
    endtask

    task automatic write_set(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        set_stb  = 1'b1;
        set_addr = a;
        set_data = d;
        @(negedge clk);
        set_stb  = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        in_if.tvalid  = 1'b1;
        out_if.tready = 1'b0;
        #1;
        total++; if (out_if.tvalid !== 1'b1) $display("FAIL rst_otvalid got %b want 1", out_if.tvalid); else passed++;
        total++; if (in_if.tready !== 1'b0) $display("FAIL rst_itready0 got %b want 0", in_if.tready); else passed++;
        out_if.tready = 1'b1;
        #1;
        total++; if (in_if.tready !== 1'b1) $display("FAIL rst_itready1 got %b want 1", in_if.tready); else passed++;
        @(negedge clk);
        rst          = 1'b0;
        in_if.tvalid = 1'b0;
        #1;
        total++; if (debug !== 32'd0) $display("FAIL rst_state got %h want 0", debug); else passed++;
        total++; if (out_if.tvalid !== 1'b0) $display("FAIL rst_idle_valid got %b want 0", out_if.tvalid); else passed++;
    endtask

    task automatic test_basic();
        drive(64'h0000_0018_0000_abcd, 1'b0);
        total++; if (out_if.tdata !== 64'h0000_0010_0000_abcd) $display("FAIL basic_hdr got %h want %h", out_if.tdata, 64'h0000_0010_0000_abcd); else passed++;
        total++; if (out_if.tlast !== 1'b0) $display("FAIL basic_hdr_last got %b want 0", out_if.tlast); else passed++;
        drive(64'h1234_5678_9abc_def0, 1'b0);
        total++; if (out_if.tvalid !== 1'b0) $display("FAIL basic_first_valid got %b want 0", out_if.tvalid); else passed++;
        total++; if (in_if.tready !== 1'b1) $display("FAIL basic_first_ready got %b want 1", in_if.tready); else passed++;
        total++; if (debug !== 32'd2) $display("FAIL basic_first_state got %h want 2", debug); else passed++;
        drive(64'h1111_2222_3333_4444, 1'b1);
        total++; if (out_if.tdata !== 64'h1256_9ade_1122_3344) $display("FAIL basic_pay got %h want %h", out_if.tdata, 64'h1256_9ade_1122_3344); else passed++;
        total++; if (out_if.tlast !== 1'b1 || out_if.tvalid !== 1'b1) $display("FAIL basic_pay_last got last=%b valid=%b want 1/1", out_if.tlast, out_if.tvalid); else passed++;
        idle();
        total++; if (debug !== 32'd0) $display("FAIL basic_end_state got %h want 0", debug); else passed++;
    endtask

    task automatic test_time();
        drive(64'h2000_001c_0000_0001, 1'b0);
        total++; if (out_if.tdata !== 64'h2000_0016_0000_0001) $display("FAIL time_hdr got %h want %h", out_if.tdata, 64'h2000_0016_0000_0001); else passed++;
        drive(64'h0000_0000_dead_beef, 1'b0);
        total++; if (out_if.tdata !== 64'h0000_0000_dead_beef) $display("FAIL time_line got %h want %h", out_if.tdata, 64'h0000_0000_dead_beef); else passed++;
        total++; if (debug !== 32'd1) $display("FAIL time_state got %h want 1", debug); else passed++;
        drive(64'haaaa_bbbb_cccc_dddd, 1'b0);
        drive(64'h0102_0304_0506_0708, 1'b1);
        total++; if (out_if.tdata !== 64'haabb_ccdd_0103_0507) $display("FAIL time_pay got %h want %h", out_if.tdata, 64'haabb_ccdd_0103_0507); else passed++;
        idle();
    endtask

    task automatic test_odd();
        drive(64'h0000_0020_0000_1234, 1'b0);
        total++; if (out_if.tdata !== 64'h0000_0014_0000_1234) $display("FAIL odd_hdr got %h want %h", out_if.tdata, 64'h0000_0014_0000_1234); else passed++;
        drive(64'h1000_2000_3000_4000, 1'b0);
        drive(64'h5000_6000_7000_8000, 1'b0);
        total++; if (out_if.tdata !== 64'h1020_3040_5060_7080 || out_if.tlast !== 1'b0) $display("FAIL odd_pay1 got %h last=%b want %h last=0", out_if.tdata, out_if.tlast, 64'h1020_3040_5060_7080); else passed++;
        drive(64'h9000_a000_b000_c000, 1'b1);
        total++; if (out_if.tdata !== 64'h90a0_b0c0_0000_0000) $display("FAIL odd_pay2 got %h want %h", out_if.tdata, 64'h90a0_b0c0_0000_0000); else passed++;
        total++; if (out_if.tlast !== 1'b1 || out_if.tvalid !== 1'b1) $display("FAIL odd_last got last=%b valid=%b want 1/1", out_if.tlast, out_if.tvalid); else passed++;
        idle();
        total++; if (debug !== 32'd0) $display("FAIL odd_end_state got %h want 0", debug); else passed++;
    endtask

    task automatic test_round();
        drive(64'h0000_0018_0000_0000, 1'b0);
        drive(64'h9abc_def0_7f80_ff80, 1'b0);
        drive(64'h0000_0000_0000_0000, 1'b1);
        total++; if (rout_if.tdata !== 64'h9bdf_7f00_0000_0000) $display("FAIL round_on got %h want %h", rout_if.tdata, 64'h9bdf_7f00_0000_0000); else passed++;
        total++; if (out_if.tdata !== 64'h9ade_7fff_0000_0000) $display("FAIL round_off got %h want %h", out_if.tdata, 64'h9ade_7fff_0000_0000); else passed++;
        idle();
    endtask

    task automatic test_sid();
        write_set(8'd0, 32'h0001_5555);
        drive(64'h0000_0018_0000_abcd, 1'b0);
        total++; if (out_if.tdata !== 64'h0000_0010_abcd_5555) $display("FAIL sid_set got %h want %h", out_if.tdata, 64'h0000_0010_abcd_5555); else passed++;
        drive(64'h0, 1'b0);
        drive(64'h0, 1'b1);
        idle();
        write_set(8'd1, 32'h0001_7777);
        drive(64'h0000_0018_0000_abcd, 1'b0);
        total++; if (out_if.tdata !== 64'h0000_0010_abcd_5555) $display("FAIL sid_other_addr got %h want %h", out_if.tdata, 64'h0000_0010_abcd_5555); else passed++;
        drive(64'h0, 1'b0);
        drive(64'h0, 1'b1);
        idle();
        write_set(8'd0, 32'h0000_0000);
        drive(64'h0000_0018_0000_abcd, 1'b0);
        total++; if (out_if.tdata !== 64'h0000_0010_0000_abcd) $display("FAIL sid_clear got %h want %h", out_if.tdata, 64'h0000_0010_0000_abcd); else passed++;
        drive(64'h0, 1'b0);
        drive(64'h0, 1'b1);
        idle();
    endtask

    task automatic test_backpressure();
        out_if.tready = 1'b0;
        drive(64'h0000_0018_0000_0007, 1'b0);
        total++; if (in_if.tready !== 1'b0 || out_if.tvalid !== 1'b1) $display("FAIL bp_hdr got ready=%b valid=%b want 0/1", in_if.tready, out_if.tvalid); else passed++;
        @(negedge clk);
        #1;
        total++; if (debug !== 32'd0) $display("FAIL bp_hdr_hold got %h want 0", debug); else passed++;
        out_if.tready = 1'b1;
        drive(64'h0102_0304_0506_0708, 1'b0);
        out_if.tready = 1'b0;
        #1;
        total++; if (in_if.tready !== 1'b1) $display("FAIL bp_first_ready got %b want 1", in_if.tready); else passed++;
        drive(64'h1112_1314_1516_1718, 1'b1);
        total++; if (out_if.tdata !== 64'h0103_0507_1113_1517 || in_if.tready !== 1'b0) $display("FAIL bp_second got %h ready=%b want %h ready=0", out_if.tdata, in_if.tready, 64'h0103_0507_1113_1517); else passed++;
        @(negedge clk);
        #1;
        total++; if (out_if.tdata !== 64'h0103_0507_1113_1517 || debug !== 32'd3) $display("FAIL bp_second_hold got %h state=%h want %h state=3", out_if.tdata, debug, 64'h0103_0507_1113_1517); else passed++;
        out_if.tready = 1'b1;
        idle();
        total++; if (debug !== 32'd0) $display("FAIL bp_end_state got %h want 0", debug); else passed++;
    endtask

    task automatic test_premature_tlast();
        drive(64'h0000_0008_0000_0042, 1'b1);
        total++; if (out_if.tdata !== 64'h0000_0008_0000_0042 || out_if.tlast !== 1'b1) $display("FAIL short_hdr got %h last=%b want %h last=1", out_if.tdata, out_if.tlast, 64'h0000_0008_0000_0042); else passed++;
        idle();
        total++; if (debug !== 32'd0) $display("FAIL short_state got %h want 0", debug); else passed++;
    endtask

    task automatic test_mid_reset();
        drive(64'h0000_0018_0000_0009, 1'b0);
        idle();
        total++; if (debug !== 32'd2) $display("FAIL mrst_pre_state got %h want 2", debug); else passed++;
        rst           = 1'b1;
        out_if.tready = 1'b0;
        #1;
        total++; if (in_if.tready !== 1'b0) $display("FAIL mrst_ready got %b want 0", in_if.tready); else passed++;
        @(negedge clk);
        rst           = 1'b0;
        out_if.tready = 1'b1;
        #1;
        total++; if (debug !== 32'd0) $display("FAIL mrst_state got %h want 0", debug); else passed++;
        drive(64'h0000_0018_0000_0009, 1'b0);
        total++; if (out_if.tdata !== 64'h0000_0010_0000_0009) $display("FAIL mrst_hdr got %h want %h", out_if.tdata, 64'h0000_0010_0000_0009); else passed++;
        drive(64'hffff_0000_8000_7fff, 1'b0);
        drive(64'h0000_0000_0000_0000, 1'b1);
        total++; if (out_if.tdata !== 64'hff00_807f_0000_0000) $display("FAIL mrst_pay got %h want %h", out_if.tdata, 64'hff00_807f_0000_0000); else passed++;
        total++; if (rout_if.tdata !== 64'h0000_807f_0000_0000) $display("FAIL mrst_pay_r got %h want %h", rout_if.tdata, 64'h0000_807f_0000_0000); else passed++;
        idle();
    endtask

    task automatic test_back_to_back();
        drive(64'h0000_0010_0000_0001, 1'b0);
        total++; if (out_if.tdata !== 64'h0000_000c_0000_0001) $display("FAIL b2b_hdr1 got %h want %h", out_if.tdata, 64'h0000_000c_0000_0001); else passed++;
        drive(64'ha000_b000_c000_d000, 1'b1);
        total++; if (out_if.tdata !== 64'ha0b0_c0d0_0000_0000 || out_if.tlast !== 1'b1) $display("FAIL b2b_pay1 got %h last=%b want %h last=1", out_if.tdata, out_if.tlast, 64'ha0b0_c0d0_0000_0000); else passed++;
        drive(64'h0000_0018_0000_0002, 1'b0);
        total++; if (out_if.tdata !== 64'h0000_0010_0000_0002 || debug !== 32'd0) $display("FAIL b2b_hdr2 got %h state=%h want %h state=0", out_if.tdata, debug, 64'h0000_0010_0000_0002); else passed++;
        drive(64'h0100_0200_0300_0400, 1'b0);
        drive(64'h0500_0600_0700_0800, 1'b1);
        total++; if (out_if.tdata !== 64'h0102_0304_0506_0708 || out_if.tlast !== 1'b1) $display("FAIL b2b_pay2 got %h last=%b want %h last=1", out_if.tdata, out_if.tlast, 64'h0102_0304_0506_0708); else passed++;
        idle();
    endtask

    initial begin
        rst           = 1'b1;
        set_stb       = 1'b0;
        set_addr      = 8'd0;
        set_data      = 32'd0;
        in_if.tdata   = 64'd0;
        in_if.tlast   = 1'b0;
        in_if.tvalid  = 1'b0;
        out_if.tready = 1'b1;
        test_reset();
        test_basic();
        test_time();
        test_odd();
        test_round();
        test_sid();
        test_backpressure();
        test_premature_tlast();
        test_mid_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/chdr_16s_to_8s.md
# chdr_16s_to_8s

Packet-aware sample-width converter for CHDR streams: takes packets carrying sc16 payload (16-bit I/Q components), reduces each component to 8 bits, and packs two input payload lines into one output line. The header length field is rewritten and the destination SID is optionally replaced. This is the narrowing stage of the sc8 path: it produces the sc8 packets that the sc8-to-sc16 widening stage consumes on the far side of the link. It has the same settings-bus and AXI-stream framing as the widening stage.

## Interface
- BASE, 0: settings-bus address of the SID register.
- ROUND, 1: 1 = round-half-up with positive saturation; 0 = truncate (take bits [15:8]).
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- i_tdata  in  64  CHDR input line.
- i_tlast  in  1  last input line of packet.
- i_tvalid  in  1  input valid.
- i_tready  out  1  input ready.
- o_tdata  out  64  CHDR output line.
- o_tlast  out  1  last output line of packet.
- o_tvalid  out  1  output valid.
- o_tready  in  1  output ready.
- set_stb  in  1  settings strobe.
- set_addr  in  8  settings address.
- set_data  in  32  settings data. Bit 16 = set_sid enable; bits [15:0] = new destination SID.
- debug  out  32  bits [1:0] = state; other bits are 0.

## Operation
- The SID register (17 bits) is written when set_stb is high and set_addr == BASE. Reset value is 0, so the SID passes through unchanged after reset.
- States: HEADER(0), TIME(1), FIRST(2), SECOND(3). Reset state is HEADER.
- HEADER:
  - hdr = 16 if i_tdata[61] else 8.
  - in_bytes = i_tdata[47:32] - hdr.
  - out_size = hdr + (in_bytes >> 1). All arithmetic is 16-bit modulo; there is no malformed-size check.
  - o_tdata = {i_tdata[63:48], out_size, set_sid ? {i_tdata[15:0], new_dst} : i_tdata[31:0]}.
  - Transition on handshake:
    - i_tlast → stay HEADER, with o_tlast = 1.
    - otherwise bit 61 set → TIME.
    - otherwise → FIRST.
- TIME: o_tdata = i_tdata. On handshake, i_tlast → HEADER; otherwise → FIRST.
- FIRST:
  - Convert the four 16-bit components c0..c3 (c0 = [63:48]) to bytes b0..b3.
  - If !i_tlast: i_tready = 1 and o_tvalid = 0. The line is accepted into hold[31:0] = {b0,b1,b2,b3}; go to SECOND.
  - If i_tlast: o_tdata = {b0,b1,b2,b3,32'h0}, o_tlast = 1, o_tvalid = i_tvalid, i_tready = o_tready. On handshake → HEADER.
- SECOND: o_tdata = {hold, b0,b1,b2,b3} built from the current line; o_tvalid = i_tvalid, i_tready = o_tready, o_tlast = i_tlast. On handshake, i_tlast → HEADER; otherwise → FIRST.
- Byte conversion:
  - ROUND=0: b = c[15:8].
  - ROUND=1: b = c[15:8] + c[7]. If c[15] = 0 and the sum overflows to 0x80, saturate to 0x7F. Negative inputs never saturate.
- In HEADER, TIME and SECOND, handshake = i_tvalid & o_tready. In FIRST with !i_tlast, handshake = i_tvalid.

## Timing
- Header, time and SECOND lines are combinational pass-through: zero latency, with combinational i_tready/o_tvalid paths.
- A FIRST line costs one input cycle with no output beat. Output line count = ceil(input payload lines / 2) + header lines.
- Reset values: state HEADER, hold 0, SID register 0.
- Outputs are combinational from state and inputs. During and immediately after rst, o_tvalid = i_tvalid and i_tready = o_tready.
- Reset mid-packet returns to HEADER, and the next input line is treated as a header. Upstream must be reset together with this block.
- A settings write that coincides with a header beat takes effect on the next header.
- No backpressure bubbles: a stalled o_tready holds the state, and hold is stable while in SECOND.

## Test plan
- Header 0x0000_0018_0000_ABCD (no time) followed by 2 payload lines, ROUND=0 → out header size 0x0010, SID 0xABCD unchanged. One payload line {12,56,9A,DE,…} with o_tlast.
- Time packet, size 0x001C (16 + 12 bytes), 2 payload lines → size 0x0016; time line passes verbatim; 1 payload line.
- Odd line count: 3 payload lines → 2 output lines. Second line has lower 32 bits = 0 and o_tlast = 1, and the block returns to HEADER.
- ROUND=1 on components 0x9ABC, 0xDEF0, 0x7F80, 0xFF80 → bytes 0x9B, 0xDF, 0x7F (saturated), 0x00.
- Write set_data 0x0001_5555 at BASE → header SID low 16 = 0x5555, and old dst moved to [31:16]. Write 0 → pass-through restored.
- Random o_tready/i_tvalid throttling, a premature tlast on the header line, and a mid-packet rst → no lost or duplicated beats, and correct re-sync on the next header.
